fm_audio_decim: RTL and testbench



---
 rtl/fm_audio_decim.sv | 132 +++++++++++++
 tb/tb_fm_audio_decim.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_audio_decim.sv
// Decimating audio back-end: boxcar average over 2^DECIM_LOG2 discriminator
// samples, leaky DC blocker, saturation to 10-bit offset binary, and a
// one-entry valid/ready output register with a sticky overrun flag.
module fm_audio_decim #(
  parameter int unsigned DECIM_LOG2 = 4,
  parameter int unsigned DC_SHIFT   = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [9:0] din,
  input  logic       clr,
  input  logic       dc_bypass,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [9:0] dout,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int unsigned SW  = 10;
  localparam int unsigned AW  = SW + DECIM_LOG2;
  localparam int unsigned YW  = 11;
  localparam int unsigned DCW = YW + DC_SHIFT;

  logic signed [SW-1:0]   s;
  logic [DECIM_LOG2-1:0]  cnt;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_sum_c;
  logic signed [SW-1:0]   avg_reg;
  logic                   s1_valid;
  logic signed [DCW-1:0]  dc_acc;
  logic signed [YW-1:0]   avg_ext_c;
  logic signed [YW-1:0]   dc_c;
  logic signed [YW-1:0]   y_c;
  logic [SW-1:0]          ys_c;
  logic [SW-1:0]          res_c;
  logic                   load_c;
  logic                   drop_c;

  // Offset binary to two's complement: flipping the MSB subtracts 512.
  assign s = {~din[9], din[8:0]};

  // Running block sum including the current sample.
  always_comb begin
    acc_sum_c = acc + {{DECIM_LOG2{s[9]}}, s};
  end

  // Stage 1: accumulate N samples, dump the floor average on the last one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      cnt      <= '0;
      avg_reg  <= '0;
      s1_valid <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      if (in_valid) begin
        if (&cnt) begin
          avg_reg  <= SW'(acc_sum_c >>> DECIM_LOG2);
          acc      <= '0;
          cnt      <= '0;
          s1_valid <= 1'b1;
        end else begin
          acc <= acc_sum_c;
          cnt <= cnt + DECIM_LOG2'(1);
        end
      end
    end
  end

  // Stage 2 datapath: subtract tracked DC, saturate, back to offset binary.
  always_comb begin
    avg_ext_c = {avg_reg[SW-1], avg_reg};
    dc_c      = YW'(dc_acc >>> DC_SHIFT);
    y_c       = dc_bypass ? avg_ext_c : avg_ext_c - dc_c;
    if (y_c[YW-1] != y_c[YW-2]) begin
      ys_c = y_c[YW-1] ? 10'h200 : 10'h1ff;
    end else begin
      ys_c = y_c[SW-1:0];
    end
    res_c  = {~ys_c[SW-1], ys_c[SW-2:0]};
    load_c = s1_valid && !clr && (!out_valid || out_ready);
    drop_c = s1_valid && !clr && out_valid && !out_ready;
  end

  // DC tracker integrates the unsaturated output, even when bypassed or dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dc_acc <= '0;
    end else if (clr) begin
      dc_acc <= '0;
    end else if (s1_valid) begin
      dc_acc <= dc_acc + {{DC_SHIFT{y_c[YW-1]}}, y_c};
    end
  end

  // One-entry output register; a new result may reload on the transfer edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      dout      <= 10'd512;
    end else begin
      if (clr) begin
        out_valid <= 1'b0;
      end else if (load_c) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load_c) begin
        dout <= res_c;
      end
    end
  end

  // Sticky overrun; a drop in the same cycle as clr_overrun wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_audio_decim.sv
// Scoreboard bench for fm_audio_decim: stimulus pushes model results,
// an independent monitor pops and compares on each output transfer.
module tb_fm_audio_decim;

  localparam int unsigned DL = 4;
  localparam int unsigned DS = 6;
  localparam int unsigned N  = 1 << DL;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic [9:0] din;
  logic       clr;
  logic       dc_bypass;
  logic       out_ready;
  logic       out_valid;
  logic [9:0] dout;
  logic       overrun;
  logic       clr_overrun;

  int     errors = 0;
  int     checks = 0;
  int     exp_q[$];
  int     blk[$];
  longint m_dc_acc = 0;
  bit     push_en = 1'b1;

  always #5 clk = ~clk;

  fm_audio_decim #(.DECIM_LOG2(DL), .DC_SHIFT(DS)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .din         (din),
    .clr         (clr),
    .dc_bypass   (dc_bypass),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .dout        (dout),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: mean of the block, minus tracked DC, clamped, re-offset by 512.
  function automatic int model_block();
    longint sum;
    longint avg;
    longint y;
    sum = 0;
    foreach (blk[i]) sum += longint'(blk[i]) - 512;
    avg = floor_div(sum, longint'(N));
    if (dc_bypass) begin
      y = avg;
    end else begin
      y = avg - floor_div(m_dc_acc, longint'(1) << DS);
      while (y > 1023) y -= 2048;
      while (y < -1024) y += 2048;
    end
    m_dc_acc += y;
    if (y > 511) y = 511;
    if (y < -512) y = -512;
    return int'(y + 512);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int d, input bit gap);
    int r;
    if (gap) idle($urandom_range(0, 2));
    in_valid = 1'b1;
    din      = 10'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    blk.push_back(d);
    if (blk.size() == N) begin
      r = model_block();
      if (push_en) exp_q.push_back(r);
      blk.delete();
    end
  endtask

  task automatic block(input int d, input bit gap);
    for (int i = 0; i < int'(N); i++) strobe(d, gap);
  endtask

  task automatic rand_block(input bit gap);
    for (int i = 0; i < int'(N); i++) strobe(int'($urandom_range(0, 1023)), gap);
  endtask

  // Strobes held high during reset must be ignored.
  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b1;
    din      = 10'd1023;
    idle(2);
    in_valid = 1'b0;
    rstn     = 1'b1;
    blk.delete();
    m_dc_acc = 0;
  endtask

  // Monitor: every transfer must match the next expected result.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", dout);
      end else begin
        check("dout", int'(dout), exp_q.pop_front());
      end
    end
  end

  initial begin
    rstn        = 1'b0;
    in_valid    = 1'b1;
    din         = 10'd700;
    clr         = 1'b0;
    dc_bypass   = 1'b0;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;
    idle(2);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_dout", int'(dout), 512);
    check("reset_overrun", int'(overrun), 0);
    in_valid = 1'b0;
    rstn     = 1'b1;

    // Zero input and two-edge latency
    block(512, 1'b0);
    @(negedge clk);
    check("latency_e0", int'(out_valid), 0);
    @(negedge clk);
    check("latency_e1", int'(out_valid), 1);
    check("zero_overrun", int'(overrun), 0);
    @(negedge clk);
    check("single_pulse", int'(out_valid), 0);

    // DC blocker bypassed: constant passes through
    do_reset();
    dc_bypass = 1'b1;
    for (int b = 0; b < 3; b++) block(612, 1'b1);
    idle(4);

    // DC blocker active: 612, 611, decaying toward 512
    do_reset();
    dc_bypass = 1'b0;
    for (int b = 0; b < 20; b++) block(612, 1'b0);
    idle(4);

    // Floor rounding: sum -8 -> avg -1 -> 511
    do_reset();
    dc_bypass = 1'b1;
    for (int i = 0; i < int'(N); i++) strobe((i % 2) ? 1023 : 0, 1'b0);
    idle(4);
    check("floor_dout", int'(dout), 511);

    // Saturation: settle at full scale, then step to zero
    do_reset();
    dc_bypass = 1'b0;
    for (int b = 0; b < 2000; b++) block(1023, 1'b0);
    idle(4);
    check("sat_settle", int'(dout), 512);
    block(0, 1'b0);
    idle(4);
    check("sat_step", int'(dout), 0);

    // Backpressure: second result dropped, overrun sticky until cleared
    do_reset();
    dc_bypass = 1'b1;
    out_ready = 1'b0;
    rand_block(1'b0);
    idle(2);
    check("bp_valid_first", int'(out_valid), 1);
    check("bp_overrun_first", int'(overrun), 0);
    push_en = 1'b0;
    rand_block(1'b0);
    push_en = 1'b1;
    idle(3);
    check("bp_overrun_set", int'(overrun), 1);
    check("bp_valid_held", int'(out_valid), 1);
    check("bp_dout_held", int'(dout), (exp_q.size() > 0) ? exp_q[0] : -1);
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_clear", int'(out_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    check("bp_overrun_clear", int'(overrun), 0);

    // Reset mid-block discards the partial sum
    for (int i = 0; i < 7; i++) strobe(int'($urandom_range(0, 1023)), 1'b0);
    do_reset();
    dc_bypass = 1'b1;
    block(612, 1'b0);
    idle(4);
    check("rst_mid_drained", exp_q.size(), 0);
    check("rst_mid_dout", int'(dout), 612);

    // clr mid-block, with a coincident strobe that clr must override
    for (int i = 0; i < 7; i++) strobe(int'($urandom_range(0, 1023)), 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    din      = 10'(1023);
    idle(1);
    clr      = 1'b0;
    in_valid = 1'b0;
    blk.delete();
    m_dc_acc = 0;
    block(612, 1'b0);
    idle(4);
    check("clr_mid_drained", exp_q.size(), 0);
    check("clr_mid_dout", int'(dout), 612);

    // Randomized blocks with random gaps and bypass settings
    do_reset();
    for (int b = 0; b < 40; b++) begin
      dc_bypass = 1'($urandom_range(0, 1));
      rand_block(1'b1);
      idle(3);
    end
    check("rand_overrun", int'(overrun), 0);

    idle(4);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
